// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative RV32M multiply/divide unit for the execute stage
//
// Purpose: computes one M-extension operation at a time. Multiply is radix-2
// shift-add, divide is radix-2 restoring, both on sign-stripped magnitudes with
// the sign fixed up while entering DONE. Divide-by-zero and signed overflow
// finish in one cycle. busy is the Controller's structure-hazard stall, and
// clear aborts the operation in flight on a branch miss.
//
// Ports:
//   clk    - clock, rising edge
//   rst    - asynchronous active-high reset
//   start  - execute stage holds an M-op (level, sampled only in IDLE)
//   op     - funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   src1   - rs1 operand, captured on accept
//   src2   - rs2 operand, captured on accept
//   clear  - abort the current operation (branch-miss flush)
//   busy   - stall request to the Controller
//   done   - one-cycle pulse, result valid
//   result - operation result, qualified by done
//
// Optional feature: define MULDIV_FAST_MUL_EN to replace the iterative
// multiply with a single-cycle combinational multiplier (divide is unchanged).

module mul_div_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] src1,
    input  logic [DATA_WIDTH-1:0] src2,
    input  logic                  clear,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_COUNT = CW'(DATA_WIDTH - 1);
    localparam logic [W-1:0]  MOST_NEG   = {1'b1, {(W-1){1'b0}}};

    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } stateType;

    stateType      state;
    stateType      stateNext;
    logic [CW-1:0] counter;
    logic [2:0]    opReg;
    logic [W-1:0]  accHi;       // multiply: running high product; divide: partial remainder
    logic [W-1:0]  accLo;       // multiply: multiplier/low product; divide: dividend/quotient
    logic [W-1:0]  operandB;    // multiplicand or divisor magnitude
    logic          negMain;     // negate product (multiply) or quotient (divide)
    logic          negRem;      // negate remainder (sign of the dividend)
    logic [W-1:0]  resultReg;

    // ---------------- operand decode, evaluated on the incoming op ----------------
    logic         aSigned;
    logic         bSigned;
    logic         aNeg;
    logic         bNeg;
    logic [W-1:0] magA;
    logic [W-1:0] magB;
    logic         divByZero;
    logic         divOverflow;
    logic         isSpecial;
    logic [W-1:0] specialResult;
    logic         accept;

    always_comb begin
        aSigned     = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
        bSigned     = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
        aNeg        = aSigned & src1[W-1];
        bNeg        = bSigned & src2[W-1];
        // -MOST_NEG wraps to itself, which is the correct unsigned magnitude
        magA        = aNeg ? -src1 : src1;
        magB        = bNeg ? -src2 : src2;
        divByZero   = op[2] && (src2 == '0);
        divOverflow = ((op == OP_DIV) || (op == OP_REM)) && (src1 == MOST_NEG) && (src2 == '1);
        isSpecial   = divByZero || divOverflow;
        // op[1] selects remainder for the divide group
        if (divByZero) begin
            specialResult = op[1] ? src1 : '1;
        end else begin
            specialResult = op[1] ? '0 : src1;
        end
    end

    assign accept = (state == IDLE) && start && !clear;

`ifdef MULDIV_FAST_MUL_EN
    // (W+1)-bit signed operands, sign-extended to the full product width so a
    // plain multiply gives the right low 2W bits for every signedness mix.
    logic           fastHit;
    logic [2*W-1:0] fastA;
    logic [2*W-1:0] fastB;
    logic [2*W-1:0] fastProd;
    logic [W-1:0]   fastResult;

    always_comb begin
        fastHit    = ~op[2];
        fastA      = {{W{aNeg}}, src1};
        fastB      = {{W{bNeg}}, src2};
        fastProd   = fastA * fastB;
        fastResult = (op[1:0] == 2'b00) ? fastProd[W-1:0] : fastProd[2*W-1:W];
    end
`else
    logic fastHit;
    assign fastHit = 1'b0;
`endif

    // ---------------- one radix-2 step on the latched operation ----------------
    logic [W:0]   mulSum;
    logic [W:0]   divShift;
    logic [W:0]   divDiff;
    logic         divFits;
    logic [W-1:0] stepHi;
    logic [W-1:0] stepLo;

    always_comb begin
        mulSum   = {1'b0, accHi} + (accLo[0] ? {1'b0, operandB} : '0);
        divShift = {accHi, accLo[W-1]};
        divDiff  = divShift - {1'b0, operandB};
        // remainder stays below the divisor, so a set top bit can only mean a borrow
        divFits  = ~divDiff[W];
        if (opReg[2]) begin
            stepHi = divFits ? divDiff[W-1:0] : divShift[W-1:0];
            stepLo = {accLo[W-2:0], divFits};
        end else begin
            stepHi = mulSum[W:1];
            stepLo = {mulSum[0], accLo[W-1:1]};
        end
    end

    // ---------------- sign fix-up applied while entering DONE ----------------
    logic [2*W-1:0] product;
    logic [2*W-1:0] productSigned;
    logic [W-1:0]   quotSigned;
    logic [W-1:0]   remSigned;
    logic [W-1:0]   finalResult;

    always_comb begin
        product       = {stepHi, stepLo};
        productSigned = negMain ? -product : product;
        quotSigned    = negMain ? -stepLo : stepLo;
        remSigned     = negRem ? -stepHi : stepHi;
        if (opReg[2]) begin
            finalResult = opReg[1] ? remSigned : quotSigned;
        end else begin
            finalResult = (opReg[1:0] == 2'b00) ? productSigned[W-1:0] : productSigned[2*W-1:W];
        end
    end

    // ---------------- FSM next state and outputs ----------------
    always_comb begin
        stateNext = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = accept;
                if (accept) begin
                    stateNext = (isSpecial || fastHit) ? DONE : CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (counter == LAST_COUNT) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                // start is the same instruction leaving execute; never re-accepted here
                done      = 1'b1;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
        if (clear) begin
            stateNext = IDLE;
        end
    end

    assign result = resultReg;

    // ---------------- state and datapath registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            counter   <= '0;
            opReg     <= '0;
            accHi     <= '0;
            accLo     <= '0;
            operandB  <= '0;
            negMain   <= 1'b0;
            negRem    <= 1'b0;
            resultReg <= '0;
        end else begin
            state <= stateNext;
            if (clear) begin
                counter <= '0;
            end else if (accept) begin
                opReg    <= op;
                counter  <= '0;
                accHi    <= '0;
                accLo    <= magA;
                operandB <= magB;
                negMain  <= aNeg ^ bNeg;
                negRem   <= aNeg;
                if (isSpecial) begin
                    resultReg <= specialResult;
                end
`ifdef MULDIV_FAST_MUL_EN
                else if (fastHit) begin
                    resultReg <= fastResult;
                end
`endif
            end else if (state == CALC) begin
                accHi   <= stepHi;
                accLo   <= stepLo;
                counter <= counter + CW'(1);
                if (counter == LAST_COUNT) begin
                    resultReg <= finalResult;
                end
            end
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - directed self-checking bench for mul_div_unit

module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] src1 = '0;
    logic [31:0] src2 = '0;
    logic        clear = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int nVec = 0;
    int nFail = 0;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    typedef struct {
        logic [2:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        int          lat;
        string       name;
    } vecT;

    mul_div_unit #(.DATA_WIDTH(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .src1   (src1),
        .src2   (src2),
        .clear  (clear),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, miscompares so far %0d", nFail);
        $fatal(1, "watchdog");
    end

    // Drives one operation starting now (caller sits at a negedge = cycle 0),
    // holds start through the DONE cycle, and reports latency, result and the
    // number of cycles whose busy level was wrong.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [31:0] res, output int busyErr);
        op = o; src1 = a; src2 = b; clear = 1'b0; start = 1'b1;
        lat = -1; res = '0; busyErr = 0;
        #1;
        if (busy !== 1'b1) busyErr++;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = c;
                res = result;
                if (busy !== 1'b0) busyErr++;
                break;
            end
            if (busy !== 1'b1) busyErr++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        nVec++; if (busy !== 1'b0) begin nFail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        nVec++; if (done !== 1'b0) begin nFail++; $display("FAIL reset_done: got %b expected 0", done); end
        nVec++; if (result !== 32'h0) begin nFail++; $display("FAIL reset_result: got %h expected 00000000", result); end
        rst = 1'b0;
    endtask

    task automatic test_mul();
        vecT v[4];
        int lat; int be; logic [31:0] res;
        v[0] = '{3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT, "mul_7_m3"};
        v[1] = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT, "mulh_min_min"};
        v[2] = '{3'b011, 32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT, "mulhu_2p31"};
        v[3] = '{3'b010, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, MUL_LAT, "mulhsu_m1_2"};
        foreach (v[i]) begin
            @(negedge clk);
            issue(v[i].o, v[i].a, v[i].b, lat, res, be);
            nVec++; if (res !== v[i].r) begin nFail++; $display("FAIL %s result: got %h expected %h", v[i].name, res, v[i].r); end
            nVec++; if (lat != v[i].lat) begin nFail++; $display("FAIL %s latency: got %0d expected %0d", v[i].name, lat, v[i].lat); end
            nVec++; if (be != 0) begin nFail++; $display("FAIL %s busy: got %0d bad cycles expected 0", v[i].name, be); end
        end
    endtask

    task automatic test_div();
        vecT v[4];
        int lat; int be; logic [31:0] res;
        v[0] = '{3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33, "div_m7_2"};
        v[1] = '{3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33, "rem_m7_2"};
        v[2] = '{3'b101, 32'd100,      32'd7, 32'd14,       33, "divu_100_7"};
        v[3] = '{3'b111, 32'd100,      32'd7, 32'd2,        33, "remu_100_7"};
        foreach (v[i]) begin
            @(negedge clk);
            issue(v[i].o, v[i].a, v[i].b, lat, res, be);
            nVec++; if (res !== v[i].r) begin nFail++; $display("FAIL %s result: got %h expected %h", v[i].name, res, v[i].r); end
            nVec++; if (lat != v[i].lat) begin nFail++; $display("FAIL %s latency: got %0d expected %0d", v[i].name, lat, v[i].lat); end
            nVec++; if (be != 0) begin nFail++; $display("FAIL %s busy: got %0d bad cycles expected 0", v[i].name, be); end
        end
    endtask

    task automatic test_special();
        vecT v[4];
        int lat; int be; logic [31:0] res;
        v[0] = '{3'b101, 32'd100,      32'd0,        32'hFFFFFFFF, 1, "divu_by_zero"};
        v[1] = '{3'b111, 32'd100,      32'd0,        32'd100,      1, "remu_by_zero"};
        v[2] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, "div_overflow"};
        v[3] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1, "rem_overflow"};
        foreach (v[i]) begin
            @(negedge clk);
            issue(v[i].o, v[i].a, v[i].b, lat, res, be);
            nVec++; if (res !== v[i].r) begin nFail++; $display("FAIL %s result: got %h expected %h", v[i].name, res, v[i].r); end
            nVec++; if (lat != v[i].lat) begin nFail++; $display("FAIL %s latency: got %0d expected %0d", v[i].name, lat, v[i].lat); end
            nVec++; if (be != 0) begin nFail++; $display("FAIL %s busy: got %0d bad cycles expected 0", v[i].name, be); end
        end
    endtask

    task automatic test_back_to_back();
        int lat; int be; logic [31:0] res;
        @(negedge clk);
        issue(3'b111, 32'd100, 32'd7, lat, res, be);
        nVec++; if (res !== 32'd2 || lat != 33) begin nFail++; $display("FAIL b2b_first: got %h at %0d expected 00000002 at 33", res, lat); end
        @(negedge clk);
        issue(3'b001, 32'hFFFFFFFE, 32'h00000003, lat, res, be);
        nVec++; if (res !== 32'hFFFFFFFF || lat != MUL_LAT) begin nFail++; $display("FAIL b2b_second: got %h at %0d expected ffffffff at %0d", res, lat, MUL_LAT); end
        @(negedge clk);
        issue(3'b101, 32'd50, 32'd0, lat, res, be);
        nVec++; if (res !== 32'hFFFFFFFF || lat != 1) begin nFail++; $display("FAIL b2b_special: got %h at %0d expected ffffffff at 1", res, lat); end
        nVec++; if (be != 0) begin nFail++; $display("FAIL b2b_busy: got %0d bad cycles expected 0", be); end
    endtask

    task automatic test_clear();
        int sawDone = 0; int lat; int be; logic [31:0] res;
        @(negedge clk);
        op = 3'b100; src1 = 32'd1000; src2 = 32'd7; clear = 1'b0; start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (done === 1'b1) sawDone++;
        end
        clear = 1'b1;
        #1;
        nVec++; if (busy !== 1'b1) begin nFail++; $display("FAIL clear_cycle10_busy: got %b expected 1", busy); end
        @(negedge clk);
        clear = 1'b0; start = 1'b0;
        #1;
        nVec++; if (busy !== 1'b0) begin nFail++; $display("FAIL clear_busy: got %b expected 0", busy); end
        nVec++; if (done !== 1'b0 || sawDone != 0) begin nFail++; $display("FAIL clear_no_done: got done=%b pulses=%0d expected 0", done, sawDone); end
        issue(3'b101, 32'd9, 32'd3, lat, res, be);
        nVec++; if (res !== 32'd3) begin nFail++; $display("FAIL clear_next_result: got %h expected 00000003", res); end
        nVec++; if (11 + lat != 44) begin nFail++; $display("FAIL clear_next_cycle: got %0d expected 44", 11 + lat); end
        // clear overrides start in IDLE
        @(negedge clk);
        op = 3'b101; src1 = 32'd9; src2 = 32'd3; start = 1'b1; clear = 1'b1;
        #1;
        nVec++; if (busy !== 1'b0) begin nFail++; $display("FAIL clear_over_start_busy: got %b expected 0", busy); end
        @(negedge clk);
        start = 1'b0; clear = 1'b0;
        #1;
        nVec++; if (busy !== 1'b0 || done !== 1'b0) begin nFail++; $display("FAIL clear_over_start_idle: got busy=%b done=%b expected 0 0", busy, done); end
        // clear in the DONE cycle still shows done
        @(negedge clk);
        op = 3'b101; src1 = 32'd5; src2 = 32'd0; start = 1'b1;
        @(negedge clk);
        clear = 1'b1;
        #1;
        nVec++; if (done !== 1'b1 || result !== 32'hFFFFFFFF) begin nFail++; $display("FAIL clear_in_done: got done=%b result=%h expected 1 ffffffff", done, result); end
        @(negedge clk);
        clear = 1'b0; start = 1'b0;
    endtask

    task automatic test_reset_mid();
        int lat; int be; logic [31:0] res;
        @(negedge clk);
        op = 3'b101; src1 = 32'd100; src2 = 32'd7; clear = 1'b0; start = 1'b1;
        repeat (15) @(negedge clk);
        #2;
        rst = 1'b1; start = 1'b0;
        #1;
        nVec++; if (busy !== 1'b0 || done !== 1'b0) begin nFail++; $display("FAIL midreset_flags: got busy=%b done=%b expected 0 0", busy, done); end
        nVec++; if (result !== 32'h0) begin nFail++; $display("FAIL midreset_result: got %h expected 00000000", result); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        issue(3'b000, 32'd3, 32'd4, lat, res, be);
        nVec++; if (res !== 32'd12) begin nFail++; $display("FAIL post_reset_mul: got %h expected 0000000c", res); end
        nVec++; if (lat != MUL_LAT) begin nFail++; $display("FAIL post_reset_latency: got %0d expected %0d", lat, MUL_LAT); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            nVec++; if (busy !== 1'b0 || done !== 1'b0) begin nFail++; $display("FAIL no_retrigger: got busy=%b done=%b expected 0 0", busy, done); end
        end
        nVec++; if (result !== 32'd12) begin nFail++; $display("FAIL result_hold: got %h expected 0000000c", result); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_back_to_back();
        test_clear();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule
